// File: rtl/rv_pkg.sv
// Shared RV32I front-end types and constants for the fetch stage.
package rv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 7;

  localparam logic [XLEN-1:0]  NOP_INSTR = 32'h0000_0013;
  localparam logic [OPC_W-1:0] OPC_OPIMM = 7'b0010011;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // IF/ID pipeline register payload
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Hazard, redirect, IMEM and decode-side signals of the fetch stage.
interface fetch_stage_if;
  import rv_pkg::*;

  logic             i_stallF;
  logic             i_stallD;
  logic             i_flushD;
  logic             i_pc_sel_ex;
  logic [XLEN-1:0]  i_target_ex;
  logic [XLEN-1:0]  o_imem_addr;
  logic [XLEN-1:0]  i_imem_rdata;
  logic [OPC_W-1:0] o_opcodeIF;
  logic [XLEN-1:0]  o_pcD;
  logic [XLEN-1:0]  o_pc4D;
  logic [XLEN-1:0]  o_instrD;
  logic             o_validD;
  logic             o_misaligned;
  logic [XLEN-1:0]  o_perf_fetch;
  logic [XLEN-1:0]  o_perf_stall;
  logic [XLEN-1:0]  o_perf_flush;

  modport master (
    input  i_stallF, i_stallD, i_flushD, i_pc_sel_ex, i_target_ex, i_imem_rdata,
    output o_imem_addr, o_opcodeIF, o_pcD, o_pc4D, o_instrD, o_validD,
    output o_misaligned, o_perf_fetch, o_perf_stall, o_perf_flush
  );

  modport slave (
    output i_stallF, i_stallD, i_flushD, i_pc_sel_ex, i_target_ex, i_imem_rdata,
    input  o_imem_addr, o_opcodeIF, o_pcD, o_pc4D, o_instrD, o_validD,
    input  o_misaligned, o_perf_fetch, o_perf_stall, o_perf_flush
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register; flush beats stall, stall beats load.
module if_id_reg
  import rv_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_reset,
  input  logic   i_flush,
  input  logic   i_stall,
  input  if_id_t i_d,
  output if_id_t o_q
);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_q.pc    <= '0;
      o_q.pc4   <= '0;
      o_q.instr <= NOP_INSTR;
      o_q.valid <= 1'b0;
    end else if (i_flush) begin
      // bubble keeps the pc fields of the killed slot
      o_q.instr <= NOP_INSTR;
      o_q.valid <= 1'b0;
    end else if (!i_stall) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC/boot/halt FSM, sync IMEM address, IF/ID register.
// Optional performance counters built when FETCH_PERF_EN is defined.
module fetch_stage
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input logic          i_clk,
  input logic          i_reset,
  fetch_stage_if.master bus
);

  fetch_state_t    state, next_state;
  logic [XLEN-1:0] pc_f, next_pc, imem_addr;
  logic            fetch_valid, set_misaligned, misaligned;
  if_id_t          if_id_d, if_id_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state      <= BOOT;
      pc_f       <= RESET_PC;
      misaligned <= 1'b0;
    end else begin
      state <= next_state;
      pc_f  <= next_pc;
      if (set_misaligned) misaligned <= 1'b1;
    end
  end

  // next-PC: redirect over stall over sequential; misaligned target halts
  always_comb begin
    next_state     = state;
    next_pc        = pc_f;
    imem_addr      = pc_f;
    fetch_valid    = 1'b0;
    set_misaligned = 1'b0;
    unique case (state)
      BOOT: begin
        imem_addr  = RESET_PC;
        next_state = RUN;
      end
      RUN: begin
        fetch_valid = !bus.i_pc_sel_ex;
        if (bus.i_pc_sel_ex) begin
          if (bus.i_target_ex[1:0] != 2'b00) begin
            next_state     = HALT;
            set_misaligned = 1'b1;
          end else begin
            next_pc = bus.i_target_ex;
          end
        end else if (!bus.i_stallF) begin
          next_pc = pc_f + XLEN'(4);
        end
        imem_addr = next_pc;
      end
      HALT: begin
        next_state = HALT;
      end
      default: begin
        next_state = BOOT;
      end
    endcase
  end

  always_comb begin
    if_id_d.pc    = pc_f;
    if_id_d.pc4   = pc_f + XLEN'(4);
    if_id_d.instr = fetch_valid ? bus.i_imem_rdata : NOP_INSTR;
    if_id_d.valid = fetch_valid;
  end

  if_id_reg u_if_id_reg (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_flush (bus.i_flushD),
    .i_stall (bus.i_stallD),
    .i_d     (if_id_d),
    .o_q     (if_id_q)
  );

  assign bus.o_imem_addr  = imem_addr;
  assign bus.o_opcodeIF   = fetch_valid ? bus.i_imem_rdata[OPC_W-1:0] : OPC_OPIMM;
  assign bus.o_pcD        = if_id_q.pc;
  assign bus.o_pc4D       = if_id_q.pc4;
  assign bus.o_instrD     = if_id_q.instr;
  assign bus.o_validD     = if_id_q.valid;
  assign bus.o_misaligned = misaligned;

`ifdef FETCH_PERF_EN
  logic [XLEN-1:0] perf_fetch, perf_stall, perf_flush;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      perf_fetch <= '0;
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (fetch_valid && !bus.i_flushD && !bus.i_stallD) perf_fetch <= perf_fetch + XLEN'(1);
      if (state == RUN && bus.i_stallF)                  perf_stall <= perf_stall + XLEN'(1);
      if (bus.i_flushD)                                  perf_flush <= perf_flush + XLEN'(1);
    end
  end

  assign bus.o_perf_fetch = perf_fetch;
  assign bus.o_perf_stall = perf_stall;
  assign bus.o_perf_flush = perf_flush;
`else
  assign bus.o_perf_fetch = '0;
  assign bus.o_perf_stall = '0;
  assign bus.o_perf_flush = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with RESET_PC = 0x100.
module tb_fetch_stage;

  logic clk;
  logic rst;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous IMEM: word at address a is {a[23:0], 8'h33}
  always @(posedge clk) bus.i_imem_rdata <= {bus.o_imem_addr[23:0], 8'h33};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  initial begin
    rst              = 1'b0;
    bus.i_stallF     = 1'b0;
    bus.i_stallD     = 1'b0;
    bus.i_flushD     = 1'b0;
    bus.i_pc_sel_ex  = 1'b0;
    bus.i_target_ex  = 32'h0;
    bus.i_imem_rdata = 32'h0;
    tick; tick;

    chk("rst_pcD",     bus.o_pcD, 32'h0);
    chk("rst_pc4D",    bus.o_pc4D, 32'h0);
    chk("rst_instrD",  bus.o_instrD, 32'h13);
    chk("rst_validD",  32'(bus.o_validD), 32'h0);
    chk("rst_misal",   32'(bus.o_misaligned), 32'h0);
    chk("rst_addr",    bus.o_imem_addr, 32'h100);
    chk("rst_pf_fet",  bus.o_perf_fetch, 32'h0);
    chk("rst_pf_stl",  bus.o_perf_stall, 32'h0);
    chk("rst_pf_fls",  bus.o_perf_flush, 32'h0);

    // boot cycle
    rst = 1'b1;
    #1;
    chk("boot_addr", bus.o_imem_addr, 32'h100);
    chk("boot_opc",  32'(bus.o_opcodeIF), 32'h13);
    tick;
    chk("run_addr",   bus.o_imem_addr, 32'h104);
    chk("run_opc",    32'(bus.o_opcodeIF), 32'h33);
    chk("run_validD", 32'(bus.o_validD), 32'h0);
    tick;
    chk("d0_pcD",    bus.o_pcD, 32'h100);
    chk("d0_pc4D",   bus.o_pc4D, 32'h104);
    chk("d0_instrD", bus.o_instrD, 32'h0001_0033);
    chk("d0_validD", 32'(bus.o_validD), 32'h1);
    chk("d0_addr",   bus.o_imem_addr, 32'h108);
    tick;
    chk("d1_pcD",  bus.o_pcD, 32'h104);
    chk("d1_addr", bus.o_imem_addr, 32'h10C);

    // one-cycle load-use stall at pcF = 0x108
    bus.i_stallF = 1'b1;
    bus.i_stallD = 1'b1;
    #1;
    chk("stall_addr", bus.o_imem_addr, 32'h108);
    tick;
    chk("stall_pcD",   bus.o_pcD, 32'h104);
    chk("stall_instr", bus.o_instrD, 32'h0001_0433);
    chk("stall_addr2", bus.o_imem_addr, 32'h108);
    bus.i_stallF = 1'b0;
    bus.i_stallD = 1'b0;
    #1;
    chk("resume_addr", bus.o_imem_addr, 32'h10C);
    tick;
    chk("resume_pcD", bus.o_pcD, 32'h108);

    // redirect to 0x200 overriding a stallF, with flushD
    bus.i_pc_sel_ex = 1'b1;
    bus.i_target_ex = 32'h200;
    bus.i_stallF    = 1'b1;
    bus.i_flushD    = 1'b1;
    #1;
    chk("redir_addr", bus.o_imem_addr, 32'h200);
    chk("redir_opc",  32'(bus.o_opcodeIF), 32'h13);
    tick;
    chk("flush_validD", 32'(bus.o_validD), 32'h0);
    chk("flush_instrD", bus.o_instrD, 32'h13);
    chk("flush_pcD",    bus.o_pcD, 32'h108);
    bus.i_pc_sel_ex = 1'b0;
    bus.i_target_ex = 32'h0;
    bus.i_stallF    = 1'b0;
    bus.i_flushD    = 1'b0;
    #1;
    chk("tgt_addr", bus.o_imem_addr, 32'h204);
    chk("tgt_opc",  32'(bus.o_opcodeIF), 32'h33);
    tick;
    chk("tgt_pcD",    bus.o_pcD, 32'h200);
    chk("tgt_instrD", bus.o_instrD, 32'h0002_0033);
    chk("tgt_validD", 32'(bus.o_validD), 32'h1);

    // flush and stall together: flush wins
    bus.i_flushD = 1'b1;
    bus.i_stallD = 1'b1;
    tick;
    chk("fs_instrD", bus.o_instrD, 32'h13);
    chk("fs_validD", 32'(bus.o_validD), 32'h0);
    chk("fs_pcD",    bus.o_pcD, 32'h200);
    bus.i_flushD = 1'b0;
    bus.i_stallD = 1'b0;

    // misaligned redirect halts
    bus.i_pc_sel_ex = 1'b1;
    bus.i_target_ex = 32'h202;
    #1;
    chk("mis_addr", bus.o_imem_addr, 32'h208);
    chk("mis_opc",  32'(bus.o_opcodeIF), 32'h13);
    tick;
    bus.i_pc_sel_ex = 1'b0;
    bus.i_target_ex = 32'h0;
    chk("mis_flag",   32'(bus.o_misaligned), 32'h1);
    chk("mis_validD", 32'(bus.o_validD), 32'h0);
    chk("mis_addr2",  bus.o_imem_addr, 32'h208);
    repeat (3) tick;
    chk("halt_flag",   32'(bus.o_misaligned), 32'h1);
    chk("halt_validD", 32'(bus.o_validD), 32'h0);
    chk("halt_addr",   bus.o_imem_addr, 32'h208);
    chk("halt_opc",    32'(bus.o_opcodeIF), 32'h13);
    chk("halt_pcD",    bus.o_pcD, 32'h208);

    // reset mid-operation with stall/flush asserted
    bus.i_stallF = 1'b1;
    bus.i_stallD = 1'b1;
    bus.i_flushD = 1'b1;
    rst = 1'b0;
    tick;
    chk("rr_pcD",    bus.o_pcD, 32'h0);
    chk("rr_instrD", bus.o_instrD, 32'h13);
    chk("rr_validD", 32'(bus.o_validD), 32'h0);
    chk("rr_misal",  32'(bus.o_misaligned), 32'h0);
    chk("rr_addr",   bus.o_imem_addr, 32'h100);

    // counter run: 10 valid fetches, 3 stall cycles, 1 flush
    bus.i_stallF = 1'b0;
    bus.i_stallD = 1'b0;
    bus.i_flushD = 1'b0;
    rst = 1'b1;
    tick;
    repeat (10) tick;
    bus.i_stallF = 1'b1;
    bus.i_stallD = 1'b1;
    repeat (3) tick;
    bus.i_stallF = 1'b0;
    bus.i_stallD = 1'b0;
    bus.i_flushD = 1'b1;
    tick;
    bus.i_flushD = 1'b0;
`ifdef FETCH_PERF_EN
    chk("perf_fetch", bus.o_perf_fetch, 32'd10);
    chk("perf_stall", bus.o_perf_stall, 32'd3);
    chk("perf_flush", bus.o_perf_flush, 32'd1);
`else
    chk("perf_fetch", bus.o_perf_fetch, 32'd0);
    chk("perf_stall", bus.o_perf_stall, 32'd0);
    chk("perf_flush", bus.o_perf_flush, 32'd0);
`endif
    chk("pc_run_pcD",   bus.o_pcD, 32'h124);
    chk("pc_run_valid", 32'(bus.o_validD), 32'h0);
    chk("pc_run_addr",  bus.o_imem_addr, 32'h130);

    // pc+4 wraps at the top of the address space
    bus.i_pc_sel_ex = 1'b1;
    bus.i_target_ex = 32'hFFFF_FFFC;
    tick;
    bus.i_pc_sel_ex = 1'b0;
    bus.i_target_ex = 32'h0;
    #1;
    chk("wrap_addr", bus.o_imem_addr, 32'h0);
    tick;
    chk("wrap_pcD",    bus.o_pcD, 32'hFFFF_FFFC);
    chk("wrap_pc4D",   bus.o_pc4D, 32'h0);
    chk("wrap_instrD", bus.o_instrD, 32'hFFFF_FC33);
    chk("wrap_validD", 32'(bus.o_validD), 32'h1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 5-stage RV32I core. Owns the PC, drives a synchronous instruction memory, and applies the hazard unit's stallF/stallD/flushD and the EX-stage redirect (pc_sel_ex plus target). Supplies the IF opcode back to the hazard unit and the registered pc/pc+4/instruction to decode. A small FSM handles post-reset boot and a sticky halt on a misaligned redirect.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  synchronous, active-low reset
- i_stallF  in  1  hold PC (hazard unit)
- i_stallD  in  1  hold IF/ID register (hazard unit)
- i_flushD  in  1  bubble IF/ID register (hazard unit)
- i_pc_sel_ex  in  1  taken branch/jump resolved in EX
- i_target_ex  in  32  redirect target from EX
- o_imem_addr  out  32  next-PC, presented to sync IMEM (data returns next cycle)
- i_imem_rdata  in  32  IMEM read data, corresponds to current pcF
- o_opcodeIF  out  7  i_imem_rdata[6:0] when fetch valid, else 7'b0010011
- o_pcD, o_pc4D  out  32  decode-stage pc and pc+4
- o_instrD  out  32  decode-stage instruction
- o_validD  out  1  o_instrD is a real instruction
- o_misaligned  out  1  sticky: redirect target[1:0] != 0
- o_perf_fetch, o_perf_stall, o_perf_flush  out  32 each  performance counters (see Configuration)

## Operation
- FSM states: BOOT, RUN, HALT. Reset -> BOOT.
- BOOT: o_imem_addr = RESET_PC, fetch invalid, pcF held; unconditional -> RUN next cycle.
- RUN next-PC priority: i_pc_sel_ex -> i_target_ex; else i_stallF -> pcF; else pcF+4. o_imem_addr = next-PC combinationally; pcF <= next-PC.
- Redirect overrides stallF in the same cycle.
- RUN -> HALT when i_pc_sel_ex=1 and i_target_ex[1:0]!=0; o_misaligned <= 1, pcF held, no redirect taken.
- HALT: fetch invalid, pcF held, o_imem_addr = pcF; exit only by reset.
- Fetch valid = state==RUN and no redirect this cycle.
- IF/ID priority: i_flushD -> o_instrD<=32'h0000_0013, o_validD<=0, pc fields held; else i_stallD -> hold all; else load pcF, pcF+4, i_imem_rdata (NOP if fetch invalid), o_validD<=fetch valid.
- Arithmetic: pc+4 is 32-bit modulo, wraps 0xFFFF_FFFC -> 0.

## Timing
- Reset values: pcF=RESET_PC, o_pcD=0, o_pc4D=0, o_instrD=32'h13, o_validD=0, o_misaligned=0, counters 0, state BOOT.
- First valid instruction in D: 2 cycles after reset deasserts (BOOT, RUN fetch, then D).
- Redirect in cycle N: o_imem_addr=target in N; pcF=target in N+1; target instruction in D with o_validD=1 in N+2. Instruction fetched in N is killed via i_flushD.
- Load-use stall (stallF=stallD=1) for one cycle: pcF, IMEM address and IF/ID all hold; IMEM re-reads same address so rdata stays consistent.
- Reset asserted mid-operation: all state returns to reset values on the next edge, regardless of stall/flush inputs.

## Configuration
- FETCH_PERF_EN defined: o_perf_fetch counts IF/ID loads with o_validD<=1; o_perf_stall counts cycles with i_stallF=1 in RUN; o_perf_flush counts cycles with i_flushD=1. All wrap modulo 2^32, clear on reset.
- Undefined: counters not built, ports present and tied to 0.

## Structure
- Shared package rv_pkg: NOP_INSTR (32'h0000_0013), OPC_OPIMM, fetch_state_t enum {BOOT, RUN, HALT}.
- One sub-module: if_id_reg (pc/pc4/instr/valid register with flush-over-stall priority).

## Test plan
- Reset release, RESET_PC=0x100 -> o_imem_addr 0x100 in BOOT; o_pcD=0x100, o_validD=1 two cycles later; o_pcD steps 0x104, 0x108.
- stallF=stallD=1 for one cycle at pcF=0x108 -> o_imem_addr stays 0x108, o_instrD/o_pcD unchanged, then resume 0x10C.
- pc_sel_ex=1, target 0x200, with stallF=1 same cycle -> o_imem_addr=0x200; flushD gives o_validD=0 next cycle; o_pcD=0x200 valid after.
- flushD=1 and stallD=1 together -> o_instrD=0x13, o_validD=0.
- pc_sel_ex=1, target 0x202 -> o_misaligned=1 sticky, state HALT, o_validD=0 thereafter until reset.
- FETCH_PERF_EN: 10 valid fetches, 3 stall cycles, 1 flush -> counters read 10/3/1; undefined -> all 0.
